// File: rtl/video_coord_gen_if.sv
// rtl/video_coord_gen_if.sv - video timing/coordinate output bundle
// Purpose: groups the raster outputs of video_coord_gen so that downstream
//          blocks (e.g. the colour-ramp mapper) take them as one port.
// Signals:
//   hsync, vsync - sync outputs at the generator's configured polarity
//   de           - data enable, high on active pixels
//   x_pos, y_pos - normalised 0..255 coordinates, zero outside active
//   sof          - one-cycle pulse on the first active pixel of a frame
// Modports: master (generator side, drives), slave (consumer side, reads).
interface video_coord_gen_if;
   logic       hsync;
   logic       vsync;
   logic       de;
   logic [7:0] x_pos;
   logic [7:0] y_pos;
   logic       sof;

   modport master (output hsync, vsync, de, x_pos, y_pos, sof);
   modport slave  (input  hsync, vsync, de, x_pos, y_pos, sof);
endinterface

// File: rtl/video_coord_gen.sv
// rtl/video_coord_gen.sv - raster timing generator with normalised x/y coordinates
// Purpose: scans an H_TOTAL x V_TOTAL frame, decodes hsync/vsync/de/sof and
//          produces 8-bit coordinates spanning 0..255 across the active area
//          using fractional accumulators instead of dividers.
// Ports:
//   clk   in  pixel clock
//   rst_n in  asynchronous active-low reset
//   en    in  pixel-clock enable; every register holds while low
//   vid   out video_coord_gen_if.master: hsync, vsync, de, x_pos, y_pos, sof
// All outputs are registered decodes of the current counter state, so they
// lag the counters by one enabled edge.
module video_coord_gen #(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter bit HS_POL   = 1'b0,
   parameter bit VS_POL   = 1'b0
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                en,
   video_coord_gen_if.master   vid
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   // +1 so the sync end bound always fits even if the back porch is zero
   localparam int HW = $clog2(H_TOTAL + 1);
   localparam int VW = $clog2(V_TOTAL + 1);

   // Accumulators must hold frac+256 < ACTIVE+256 <= 2*ACTIVE; keep at least 10 bits
   localparam int XW = ($clog2(H_ACTIVE) + 1 < 10) ? 10 : $clog2(H_ACTIVE) + 1;
   localparam int YW = ($clog2(V_ACTIVE) + 1 < 10) ? 10 : $clog2(V_ACTIVE) + 1;

   localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
   localparam logic [HW-1:0] H_ACT      = HW'(H_ACTIVE);
   localparam logic [HW-1:0] H_ACT_LAST = HW'(H_ACTIVE - 1);
   localparam logic [HW-1:0] HS_START   = HW'(H_ACTIVE + H_FP);
   localparam logic [HW-1:0] HS_END     = HW'(H_ACTIVE + H_FP + H_SYNC);

   localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
   localparam logic [VW-1:0] V_ACT      = VW'(V_ACTIVE);
   localparam logic [VW-1:0] V_ACT_LAST = VW'(V_ACTIVE - 1);
   localparam logic [VW-1:0] VS_START   = VW'(V_ACTIVE + V_FP);
   localparam logic [VW-1:0] VS_END     = VW'(V_ACTIVE + V_FP + V_SYNC);

   localparam logic [XW-1:0] X_STEP = XW'(256);
   localparam logic [XW-1:0] X_DIV  = XW'(H_ACTIVE);
   localparam logic [YW-1:0] Y_STEP = YW'(256);
   localparam logic [YW-1:0] Y_DIV  = YW'(V_ACTIVE);

   logic [HW-1:0] h_cnt;
   logic [VW-1:0] v_cnt;
   logic [XW-1:0] x_frac;
   logic [YW-1:0] y_frac;
   logic [7:0]    x_int;
   logic [7:0]    y_int;

   logic          h_wrap;
   logic          v_wrap;
   logic          de_next;
   logic [XW-1:0] x_t;
   logic [YW-1:0] y_t;

   assign h_wrap  = (h_cnt == H_LAST);
   assign v_wrap  = (v_cnt == V_LAST);
   assign de_next = (h_cnt < H_ACT) && (v_cnt < V_ACT);
   assign x_t     = x_frac + X_STEP;
   assign y_t     = y_frac + Y_STEP;

   // Invariant: x_int*H_ACTIVE + x_frac == h_cnt*256 with x_frac < H_ACTIVE.
   // Since 256 <= H_ACTIVE one step raises x_int by at most one. Stepping stops
   // once h_cnt reaches H_ACTIVE-1, so x_int never exceeds 255 and fits 8 bits.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         h_cnt     <= '0;
         v_cnt     <= '0;
         x_frac    <= '0;
         y_frac    <= '0;
         x_int     <= '0;
         y_int     <= '0;
         vid.de    <= 1'b0;
         vid.sof   <= 1'b0;
         vid.x_pos <= '0;
         vid.y_pos <= '0;
         vid.hsync <= ~HS_POL;
         vid.vsync <= ~VS_POL;
      end else if (en) begin
         h_cnt <= h_wrap ? '0 : h_cnt + 1'b1;

         if (h_wrap) begin
            x_frac <= '0;
            x_int  <= '0;
         end else if (h_cnt < H_ACT_LAST) begin
            if (x_t >= X_DIV) begin
               x_frac <= x_t - X_DIV;
               x_int  <= x_int + 8'd1;
            end else begin
               x_frac <= x_t;
            end
         end

         // Vertical state steps once per line, on the same edge as the h wrap
         if (h_wrap) begin
            v_cnt <= v_wrap ? '0 : v_cnt + 1'b1;
            if (v_wrap) begin
               y_frac <= '0;
               y_int  <= '0;
            end else if (v_cnt < V_ACT_LAST) begin
               if (y_t >= Y_DIV) begin
                  y_frac <= y_t - Y_DIV;
                  y_int  <= y_int + 8'd1;
               end else begin
                  y_frac <= y_t;
               end
            end
         end

         vid.de    <= de_next;
         vid.sof   <= (h_cnt == '0) && (v_cnt == '0);
         vid.x_pos <= de_next ? x_int : 8'd0;
         vid.y_pos <= de_next ? y_int : 8'd0;
         vid.hsync <= ((h_cnt >= HS_START) && (h_cnt < HS_END)) ? HS_POL : ~HS_POL;
         vid.vsync <= ((v_cnt >= VS_START) && (v_cnt < VS_END)) ? VS_POL : ~VS_POL;
      end
   end

endmodule

// File: tb/tb_video_coord_gen.sv
// tb/tb_video_coord_gen.sv - self-checking bench for video_coord_gen
module tb_video_coord_gen;

   logic clk = 1'b0;
   logic rst_a, en_a, rst_b, en_b;

   video_coord_gen_if vid_a ();
   video_coord_gen_if vid_b ();

   // Default 640x480 timing
   video_coord_gen u_dut_a (
      .clk   (clk),
      .rst_n (rst_a),
      .en    (en_a),
      .vid   (vid_a.master)
   );

   // 256x256 active with minimal porches and positive syncs
   video_coord_gen #(
      .H_ACTIVE(256), .H_FP(1), .H_SYNC(2), .H_BP(1),
      .V_ACTIVE(256), .V_FP(1), .V_SYNC(2), .V_BP(1),
      .HS_POL(1'b1),  .VS_POL(1'b1)
   ) u_dut_b (
      .clk   (clk),
      .rst_n (rst_b),
      .en    (en_b),
      .vid   (vid_b.master)
   );

   always #5 clk = ~clk;

   typedef struct {
      int de, hs, vs, sof, x, y;
   } vout_t;

   typedef struct {
      int ha, hfp, hsw, hbp, va, vfp, vsw, vbp, hp, vp;
   } tcfg_t;

   tcfg_t cfg_a = '{640, 16, 96, 48, 480, 10, 2, 33, 0, 0};
   tcfg_t cfg_b = '{256, 1, 2, 1, 256, 1, 2, 1, 1, 1};

   int    n_checks = 0;
   int    n_errors = 0;
   int    a_h, a_v, b_h, b_v;
   vout_t exp_a, exp_b;

   task automatic check(input string tag, input int got, input int exp);
      n_checks++;
      if (got != exp) begin
         n_errors++;
         if (n_errors <= 30)
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Expected outputs for a raster position, straight from the timing rules
   function automatic vout_t ref_out(input tcfg_t c, input int h, input int v);
      vout_t o;
      o.de  = (h < c.ha && v < c.va) ? 1 : 0;
      o.x   = o.de ? (h * 256) / c.ha : 0;
      o.y   = o.de ? (v * 256) / c.va : 0;
      o.hs  = (h >= c.ha + c.hfp && h < c.ha + c.hfp + c.hsw) ? c.hp : 1 - c.hp;
      o.vs  = (v >= c.va + c.vfp && v < c.va + c.vfp + c.vsw) ? c.vp : 1 - c.vp;
      o.sof = (h == 0 && v == 0) ? 1 : 0;
      return o;
   endfunction

   function automatic vout_t reset_out(input tcfg_t c);
      vout_t o;
      o.de = 0; o.x = 0; o.y = 0; o.sof = 0;
      o.hs = 1 - c.hp;
      o.vs = 1 - c.vp;
      return o;
   endfunction

   task automatic check_a(input string pfx);
      check({pfx, ".de"},    int'(vid_a.de),    exp_a.de);
      check({pfx, ".sof"},   int'(vid_a.sof),   exp_a.sof);
      check({pfx, ".x_pos"}, int'(vid_a.x_pos), exp_a.x);
      check({pfx, ".y_pos"}, int'(vid_a.y_pos), exp_a.y);
      check({pfx, ".hsync"}, int'(vid_a.hsync), exp_a.hs);
      check({pfx, ".vsync"}, int'(vid_a.vsync), exp_a.vs);
   endtask

   task automatic check_b(input string pfx);
      check({pfx, ".de"},    int'(vid_b.de),    exp_b.de);
      check({pfx, ".sof"},   int'(vid_b.sof),   exp_b.sof);
      check({pfx, ".x_pos"}, int'(vid_b.x_pos), exp_b.x);
      check({pfx, ".y_pos"}, int'(vid_b.y_pos), exp_b.y);
      check({pfx, ".hsync"}, int'(vid_b.hsync), exp_b.hs);
      check({pfx, ".vsync"}, int'(vid_b.vsync), exp_b.vs);
   endtask

   // One clock for DUT A: the model only moves on enabled edges, so a held
   // output under en=0 is checked against the unchanged expectation.
   task automatic step_a(input bit e, input string pfx);
      en_a = e;
      @(posedge clk);
      if (e) begin
         exp_a = ref_out(cfg_a, a_h, a_v);
         a_h++;
         if (a_h == 800) begin
            a_h = 0;
            a_v = (a_v == 524) ? 0 : a_v + 1;
         end
      end
      @(negedge clk);
      check_a(pfx);
   endtask

   task automatic step_b(input string pfx);
      en_b = 1'b1;
      @(posedge clk);
      exp_b = ref_out(cfg_b, b_h, b_v);
      b_h++;
      if (b_h == 260) begin
         b_h = 0;
         b_v = (b_v == 259) ? 0 : b_v + 1;
      end
      @(negedge clk);
      check_b(pfx);
   endtask

   initial begin
      int cnt_hs, cnt_sof, cnt_vs, guard;
      rst_a = 1'b0; rst_b = 1'b0; en_a = 1'b0; en_b = 1'b0;
      a_h = 0; a_v = 0; b_h = 0; b_v = 0;
      exp_a = reset_out(cfg_a);
      exp_b = reset_out(cfg_b);

      @(negedge clk);
      check_a("rst_a");
      check_b("rst_b");

      // Release with en low: outputs must keep reset values
      rst_a = 1'b1;
      step_a(1'b0, "hold_after_rst");
      step_a(1'b0, "hold_after_rst");

      // Line 0 and line 1 with en always high; count hsync-asserted cycles on line 1
      for (int i = 0; i < 800; i++) step_a(1'b1, "line0");
      cnt_hs = 0;
      for (int i = 0; i < 800; i++) begin
         step_a(1'b1, "line1");
         if (vid_a.hsync == 1'b0) cnt_hs++;
      end
      check("hsync_low_cycles", cnt_hs, 96);

      // Random enable: coordinate sequence must match the free-running model
      for (int i = 0; i < 3200; i++) step_a(1'($urandom % 2), "en_toggle");

      // Advance to pixel 300 of the current line, then reset mid-line
      guard = 0;
      while (a_h != 300 && guard < 2000) begin
         step_a(1'b1, "to_h300");
         guard++;
      end
      check("reach_h300", a_h, 300);
      #2;
      rst_a = 1'b0;
      #1;
      exp_a = reset_out(cfg_a);
      check_a("async_rst");
      a_h = 0; a_v = 0;
      @(negedge clk);
      check_a("in_rst");
      rst_a = 1'b1;
      step_a(1'b1, "post_rst_first");
      check("post_rst_sof", int'(vid_a.sof), 1);
      for (int i = 0; i < 900; i++) step_a(1'b1, "post_rst");
      en_a = 1'b0;

      // Full frame plus a margin on the 256x256 instance
      rst_b = 1'b1;
      cnt_sof = 0;
      cnt_vs  = 0;
      for (int i = 0; i < 260 * 260 + 20; i++) begin
         step_b("b_frame");
         if (vid_b.sof) cnt_sof++;
         if (vid_b.vsync) cnt_vs++;
      end
      check("b_sof_count", cnt_sof, 2);
      check("b_vsync_cycles", cnt_vs, 2 * 260);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/video_coord_gen.md
Name: video_coord_gen

Overview:
- Raster timing generator that sits directly upstream of the 2-D colour-ramp mapper.
- Scans a parameterised video frame and emits hsync, vsync and data-enable.
- Also emits 8-bit normalised pixel coordinates x_pos/y_pos, each spanning 0..255 across the active area; these feed the mapper's X/Y inputs.
- Normalisation uses fractional accumulators, not dividers, so the block runs at pixel clock on Spartan-6.

Parameters:
H_ACTIVE, 640, active pixels per line (must be >= 256)
H_FP, 16, horizontal front porch, pixels
H_SYNC, 96, hsync width, pixels
H_BP, 48, horizontal back porch, pixels
V_ACTIVE, 480, active lines per frame (must be >= 256)
V_FP, 10, vertical front porch, lines
V_SYNC, 2, vsync width, lines
V_BP, 33, vertical back porch, lines
HS_POL, 0, hsync asserted level
VS_POL, 0, vsync asserted level

Ports:
clk  in  1  pixel clock
rst_n  in  1  asynchronous active-low reset
en  in  1  pixel-clock enable; all state advances only when high
hsync  out  1  horizontal sync, HS_POL when asserted
vsync  out  1  vertical sync, VS_POL when asserted
de  out  1  data enable, high on active pixels
x_pos  out  8  normalised column, 0..255, valid when de
y_pos  out  8  normalised row, 0..255, valid when de
sof  out  1  one-cycle pulse on first active pixel of a frame

Behaviour:
- Derived totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise.
- Counters:
  - h_cnt runs 0..H_TOTAL-1 and wraps to 0.
  - v_cnt increments when h_cnt wraps; it runs 0..V_TOTAL-1 and wraps to 0.
  - Counters and accumulators update only on rising clk with en=1. With en=0 every register, outputs included, holds.
- Horizontal normalisation:
  - Accumulator x_frac (10 bits min; width = clog2(H_ACTIVE)+1) and integer x_int.
  - At h_cnt wrap: x_frac=0, x_int=0.
  - Otherwise each pixel: t = x_frac+256. If t >= H_ACTIVE, then x_frac = t-H_ACTIVE and x_int++; else x_frac = t.
  - Result: x_int = floor(h_cnt*256/H_ACTIVE). For h_cnt = H_ACTIVE-1 this is 255; it never reaches 256.
  - x_int freezes once h_cnt >= H_ACTIVE; its value is don't-care outside active.
- Vertical normalisation: same scheme, stepped once per line at h_cnt wrap, reset at v_cnt wrap. y_int = floor(v_cnt*256/V_ACTIVE).
- Output decode, evaluated from the current counter state and registered, giving 1-cycle latency:
  - de = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE).
  - hsync = HS_POL when H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC, else ~HS_POL.
  - vsync = VS_POL when V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC, else ~VS_POL. vsync changes on the same cycle as the h_cnt wrap.
  - x_pos = x_int[7:0], y_pos = y_int[7:0]; both forced to 0 when de would be 0.
  - sof = (h_cnt==0 && v_cnt==0).
- Reset (rst_n low, async):
  - h_cnt, v_cnt, accumulators = 0.
  - de=0, sof=0, x_pos=0, y_pos=0, hsync=~HS_POL, vsync=~VS_POL.
- After rst_n deasserts, the first enabled edge presents pixel (0,0): de=1, sof=1, x_pos=0, y_pos=0.
- Reset mid-frame aborts the frame immediately. There is no partial-frame recovery.
- Boundary conditions:
  - Last active pixel (H_ACTIVE-1, V_ACTIVE-1) outputs x_pos=255, y_pos=255.
  - Frame wrap goes from h=H_TOTAL-1, v=V_TOTAL-1 straight to (0,0) with no gap cycle.
  - en toggling mid-line must not skip or repeat any coordinate.

Test Plan:
- Reset, default params, en=1: cycle 1 gives de=1, sof=1, x_pos=0, y_pos=0. Pixel 639 of line 0 gives x_pos=255. Pixel 640 gives de=0, x_pos=0.
- Column sweep on line 0: x_pos sequence equals floor(i*256/640) for i=0..639, e.g. i=3 gives 1 and i=5 gives 2. Each value 0..255 appears 2 or 3 times.
- Full frame: 800 cycles per line and 525 lines per frame. hsync low exactly for h=656..751. vsync low exactly for lines 490..491. Line 479 gives y_pos=255. Exactly one sof per 420000 cycles.
- en toggling at a pseudo-random 50% rate: the sequence of outputs sampled on en=1 edges is identical to the en=1-always run.
- Assert rst_n low at h=300, v=200 with clk running: outputs take reset values asynchronously, before the next edge. Release gives sof on the first enabled edge.
- Override H_ACTIVE=256, V_ACTIVE=256: x_pos equals h_cnt and y_pos equals v_cnt on every active pixel.
